// File: rtl/rs232_rcvr_core.sv
// RS-232 receiver core: 8N1 framing, mid-bit sampling, level-style ready flag
// with sticky framing/overrun error flags cleared by the consumer's rdrst pulse.
module rs232_rcvr_core #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       genclk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rdrst,
  output logic [7:0] rbr,
  output logic       rdrdy,
  output logic       ferr,
  output logic       overrun
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF   = CLKS_PER_BIT / 2;
  localparam int unsigned SETTLE = 2;

  localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_SETTLE  = CNT_W'(SETTLE);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bitcnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       rbr_q;
  logic             rdrdy_q;
  logic             ferr_q;
  logic             overrun_q;
  logic             rx_meta_q;
  logic             rxs_q;

  // Two-flop synchroniser for the asynchronous serial line, idling high
  always_ff @(posedge genclk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rxs_q     <= rx_meta_q;
    end
  end

  // Receive FSM with baud counter, shift register and host-visible flags
  always_ff @(posedge genclk) begin
    if (rst) begin
      state_q   <= WAIT_IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      rbr_q     <= '0;
      rdrdy_q   <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // Consumer acknowledge; a same-cycle load or framing error below overrides it
      if (rdrst) begin
        rdrdy_q   <= 1'b0;
        ferr_q    <= 1'b0;
        overrun_q <= 1'b0;
      end

      case (state_q)
        WAIT_IDLE: begin
          // Sync flops are seeded high by reset, so ignore rxs until they have flushed
          if (rxs_q && (cnt_q == CNT_SETTLE)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q != CNT_SETTLE) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        IDLE: begin
          if (!rxs_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end

        START: begin
          if (cnt_q == CNT_HALF_M1) begin
            cnt_q <= '0;
            if (rxs_q) begin
              state_q <= IDLE;
            end else begin
              state_q  <= DATA;
              bitcnt_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q             <= '0;
            shift_q[bitcnt_q] <= rxs_q;
            bitcnt_q          <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (rxs_q) begin
              state_q <= IDLE;
              if (!rdrdy_q || rdrst) begin
                rbr_q   <= shift_q;
                rdrdy_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= WAIT_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rbr     = rbr_q;
  assign rdrdy   = rdrdy_q;
  assign ferr    = ferr_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_rs232_rcvr_core.sv
// Directed bench for rs232_rcvr_core at 16 clocks per bit.
module tb_rs232_rcvr_core;

  logic       genclk;
  logic       rst;
  logic       rxd;
  logic       rdrst;
  logic [7:0] rbr;
  logic       rdrdy;
  logic       ferr;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  rs232_rcvr_core #(.CLKS_PER_BIT(16)) dut (
    .genclk (genclk),
    .rst    (rst),
    .rxd    (rxd),
    .rdrst  (rdrst),
    .rbr    (rbr),
    .rdrdy  (rdrdy),
    .ferr   (ferr),
    .overrun(overrun)
  );

  initial genclk = 1'b0;
  always #5 genclk = ~genclk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge genclk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_rdrst();
    rdrst = 1'b1;
    tick();
    rdrst = 1'b0;
  endtask

  // Drive the first nsteps clocks of a 16x frame; rdrst is high on step rdrst_at
  task automatic send(input logic [7:0] d, input logic stop, input int rdrst_at,
                      input int nsteps);
    for (int i = 0; i < nsteps; i++) begin
      if (i < 16)       rxd = 1'b0;
      else if (i < 144) rxd = d[(i - 16) / 16];
      else              rxd = stop;
      rdrst = (i == rdrst_at);
      tick();
    end
    rdrst = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst   = 1'b1;
    rxd   = 1'b1;
    rdrst = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    chk("reset_rbr", rbr, 8'h00);
    chk("reset_rdrdy", {7'd0, rdrdy}, 8'h00);
    chk("reset_ferr", {7'd0, ferr}, 8'h00);
    chk("reset_overrun", {7'd0, overrun}, 8'h00);
    idle(20);

    // 1: good frame 0xA5, then acknowledge
    send(8'hA5, 1'b1, -1, 160);
    idle(4);
    chk("t1_rdrdy", {7'd0, rdrdy}, 8'h01);
    chk("t1_rbr", rbr, 8'hA5);
    chk("t1_ferr", {7'd0, ferr}, 8'h00);
    chk("t1_overrun", {7'd0, overrun}, 8'h00);
    pulse_rdrst();
    chk("t1_rdrdy_clr", {7'd0, rdrdy}, 8'h00);
    chk("t1_rbr_hold", rbr, 8'hA5);

    // 2: 4-cycle glitch is a false start, then frame 0x3C
    rxd = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    idle(30);
    chk("t2_glitch_rdrdy", {7'd0, rdrdy}, 8'h00);
    chk("t2_glitch_rbr", rbr, 8'hA5);
    send(8'h3C, 1'b1, -1, 160);
    idle(4);
    chk("t2_rbr", rbr, 8'h3C);
    chk("t2_rdrdy", {7'd0, rdrdy}, 8'h01);
    pulse_rdrst();
    chk("t2_rdrdy_clr", {7'd0, rdrdy}, 8'h00);

    // 3: bad stop bit with line held low, recovery, then 0x81
    send(8'h55, 1'b0, -1, 160);
    rxd = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("t3_ferr", {7'd0, ferr}, 8'h01);
    chk("t3_rdrdy", {7'd0, rdrdy}, 8'h00);
    chk("t3_rbr_old", rbr, 8'h3C);
    idle(20);
    send(8'h81, 1'b1, -1, 160);
    idle(4);
    chk("t3_rbr_new", rbr, 8'h81);
    chk("t3_rdrdy_new", {7'd0, rdrdy}, 8'h01);
    chk("t3_ferr_sticky", {7'd0, ferr}, 8'h01);
    pulse_rdrst();
    chk("t3_ferr_clr", {7'd0, ferr}, 8'h00);
    chk("t3_rdrdy_clr", {7'd0, rdrdy}, 8'h00);

    // 4: second byte while unread is dropped and flags overrun
    send(8'h11, 1'b1, -1, 160);
    idle(4);
    send(8'h22, 1'b1, -1, 160);
    idle(4);
    chk("t4_rbr", rbr, 8'h11);
    chk("t4_rdrdy", {7'd0, rdrdy}, 8'h01);
    chk("t4_overrun", {7'd0, overrun}, 8'h01);
    chk("t4_ferr", {7'd0, ferr}, 8'h00);

    // 5: rdrst coincides with the stop sample (edge 155 of the frame); load wins
    send(8'h77, 1'b1, 154, 160);
    idle(4);
    chk("t5_rbr", rbr, 8'h77);
    chk("t5_rdrdy", {7'd0, rdrdy}, 8'h01);
    chk("t5_overrun", {7'd0, overrun}, 8'h00);

    // 6: reset during data bit 3 of 0xF0 with the line low at release
    send(8'hF0, 1'b1, -1, 72);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rbr", rbr, 8'h00);
    chk("t6_rdrdy", {7'd0, rdrdy}, 8'h00);
    chk("t6_ferr", {7'd0, ferr}, 8'h00);
    chk("t6_overrun", {7'd0, overrun}, 8'h00);
    rxd = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("t6_low_rdrdy", {7'd0, rdrdy}, 8'h00);
    chk("t6_low_ferr", {7'd0, ferr}, 8'h00);
    idle(20);
    send(8'h0F, 1'b1, -1, 160);
    idle(4);
    chk("t6_rbr_new", rbr, 8'h0F);
    chk("t6_rdrdy_new", {7'd0, rdrdy}, 8'h01);
    chk("t6_overrun_new", {7'd0, overrun}, 8'h00);
    chk("t6_ferr_new", {7'd0, ferr}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
